// File: rtl/sm4_req_arbiter.sv
// Round-robin arbiter sharing one SM4 engine among four requesters, one transaction at a time.
// Optional per-requester saturating completion counters: define SM4_ARB_PERF_EN.
module sm4_req_arbiter #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [3:0]            req_v_i,
    input  logic [4*DATA_W-1:0]   req_data_i,
    input  logic [3:0]            req_dec_i,
    output logic [3:0]            req_ready_o,
    output logic                  eng_v_o,
    output logic [DATA_W-1:0]     eng_data_o,
    output logic                  eng_dec_o,
    input  logic                  eng_ready_i,
    input  logic                  eng_resp_v_i,
    input  logic [DATA_W-1:0]     eng_resp_data_i,
    output logic                  eng_resp_ready_o,
    output logic [3:0]            resp_v_o,
    output logic [DATA_W-1:0]     resp_data_o,
    input  logic [3:0]            resp_ready_i,
    output logic                  busy_o,
    output logic [1:0]            grant_id_o
`ifdef SM4_ARB_PERF_EN
    ,
    output logic [4*CNT_W-1:0]    perf_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [2:0] lsb_pick(input logic [3:0] v);
        logic [2:0] r;
        if (v[0]) begin
            r = 3'b100;
        end else if (v[1]) begin
            r = 3'b101;
        end else if (v[2]) begin
            r = 3'b110;
        end else if (v[3]) begin
            r = 3'b111;
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    state_e              state_q, state_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [1:0]          grant_q, grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                dec_q, dec_d;

    logic [3:0]          masked_s;
    logic [2:0]          pick_m_s;
    logic [2:0]          pick_u_s;
    logic [1:0]          pick_id_s;
    logic                pick_v_s;

    if (CNT_W < 1 || DATA_W < 1) begin : g_param_invalid
        $error("sm4_req_arbiter: DATA_W and CNT_W must be positive");
    end

    // Two priority encoders: requesters at/above rr_ptr first, otherwise lowest overall.
    always_comb begin
        masked_s  = req_v_i & ~((4'b0001 << rr_ptr_q) - 4'b0001);
        pick_m_s  = lsb_pick(masked_s);
        pick_u_s  = lsb_pick(req_v_i);
        pick_v_s  = pick_u_s[2];
        if (pick_m_s[2]) begin
            pick_id_s = pick_m_s[1:0];
        end else begin
            pick_id_s = pick_u_s[1:0];
        end
    end

    // Next-state and output decode; data_q holds the request in ISSUE and the result in RESP.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        grant_d          = grant_q;
        data_d           = data_q;
        dec_d            = dec_q;
        req_ready_o      = 4'b0000;
        eng_v_o          = 1'b0;
        eng_data_o       = {DATA_W{1'b0}};
        eng_dec_o        = 1'b0;
        eng_resp_ready_o = 1'b0;
        resp_v_o         = 4'b0000;
        resp_data_o      = {DATA_W{1'b0}};
        busy_o           = (state_q != ST_IDLE);
        grant_id_o       = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_v_s) begin
                    req_ready_o = 4'b0001 << pick_id_s;
                    grant_d     = pick_id_s;
                    data_d      = req_data_i[pick_id_s*DATA_W +: DATA_W];
                    dec_d       = req_dec_i[pick_id_s];
                    state_d     = ST_ISSUE;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                eng_v_o    = 1'b1;
                eng_data_o = data_q;
                eng_dec_o  = dec_q;
                if (eng_ready_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                eng_resp_ready_o = 1'b1;
                if (eng_resp_v_i) begin
                    data_d  = eng_resp_data_i;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                resp_v_o    = 4'b0001 << grant_q;
                resp_data_o = data_q;
                if (resp_ready_i[grant_q]) begin
                    rr_ptr_d = grant_q + 2'd1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 2'd0;
            grant_q  <= 2'd0;
            data_q   <= {DATA_W{1'b0}};
            dec_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            dec_q    <= dec_d;
        end
    end

`ifdef SM4_ARB_PERF_EN
    logic resp_hs_s;

    // A completion is the response handshake of the current owner.
    always_comb begin
        resp_hs_s = (state_q == ST_RESP) && resp_ready_i[grant_q];
    end

    for (genvar g = 0; g < 4; g++) begin : g_perf
        logic [CNT_W-1:0] cnt_q;

        // Saturating completion counter for requester g.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= {CNT_W{1'b0}};
            end else if (resp_hs_s && (grant_q == 2'(g)) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_q <= cnt_q;
            end
        end

        assign perf_cnt_o[g*CNT_W +: CNT_W] = cnt_q;
    end
`else
`endif

endmodule

// File: tb/tb_sm4_req_arbiter.sv
// Self-checking bench for sm4_req_arbiter: hand-computed vector table, corner sequences,
// and randomized transactions checked against a round-robin reference model.
module tb_sm4_req_arbiter;
    localparam int DW = 32;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [3:0]        req_v_i;
    logic [4*DW-1:0]   req_data_i;
    logic [3:0]        req_dec_i;
    logic [3:0]        req_ready_o;
    logic              eng_v_o;
    logic [DW-1:0]     eng_data_o;
    logic              eng_dec_o;
    logic              eng_ready_i;
    logic              eng_resp_v_i;
    logic [DW-1:0]     eng_resp_data_i;
    logic              eng_resp_ready_o;
    logic [3:0]        resp_v_o;
    logic [DW-1:0]     resp_data_o;
    logic [3:0]        resp_ready_i;
    logic              busy_o;
    logic [1:0]        grant_id_o;
`ifdef SM4_ARB_PERF_EN
    logic [4*CW-1:0]   perf_cnt_o;
    int                perf_m [4];
`endif

    always #5 clk = ~clk;

    sm4_req_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_v_i(req_v_i), .req_data_i(req_data_i), .req_dec_i(req_dec_i),
        .req_ready_o(req_ready_o),
        .eng_v_o(eng_v_o), .eng_data_o(eng_data_o), .eng_dec_o(eng_dec_o),
        .eng_ready_i(eng_ready_i),
        .eng_resp_v_i(eng_resp_v_i), .eng_resp_data_i(eng_resp_data_i),
        .eng_resp_ready_o(eng_resp_ready_o),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_ready_i(resp_ready_i),
        .busy_o(busy_o), .grant_id_o(grant_id_o)
`ifdef SM4_ARB_PERF_EN
        , .perf_cnt_o(perf_cnt_o)
`endif
    );

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    typedef struct {
        logic [3:0] rv;
        logic [3:0] exp_ready;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Round robin: first requesting index scanning upward from the pointer, wrapping.
    function automatic logic [3:0] model_grant(input logic [3:0] rv);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (ptr_m + k) % 4;
            if (rv[idx]) return 4'b0001 << idx;
        end
        return 4'b0000;
    endfunction

    function automatic logic [DW-1:0] eng_fn(input logic [DW-1:0] d, input logic dec);
        return dec ? ~d : (d ^ 32'hC3A5_5A3C);
    endfunction

    task automatic model_reset();
        ptr_m = 0;
`ifdef SM4_ARB_PERF_EN
        for (int k = 0; k < 4; k++) perf_m[k] = 0;
`endif
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_eng"}, {eng_v_o, eng_dec_o, eng_resp_ready_o, busy_o}, 64'h0);
        chk({tag, "_eng_data"}, eng_data_o, 64'h0);
        chk({tag, "_resp_v"}, resp_v_o, 64'h0);
        chk({tag, "_resp_data"}, resp_data_o, 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_v_i = 4'b0000; eng_ready_i = 1'b0; eng_resp_v_i = 1'b0; resp_ready_i = 4'b0000;
        rst_ni = 1'b0;
        #1;
        chk_quiet("rst");
        chk("rst_ready", req_ready_o, 64'h0);
        chk("rst_grant", grant_id_o, 64'h0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // One full transaction; exp_oh is the expected one-hot grant (0 = nothing accepted).
    task automatic run_txn(input logic [3:0] rv, input logic [3:0] exp_oh,
                           input int lat, input int stall, input int hold);
        logic [DW-1:0] d [4];
        logic [3:0]    dec;
        logic [DW-1:0] res;
        int            g;
        @(negedge clk);
        for (int k = 0; k < 4; k++) d[k] = $urandom;
        dec        = 4'($urandom);
        req_data_i = {d[3], d[2], d[1], d[0]};
        req_dec_i  = dec;
        req_v_i    = rv;
        #1;
        chk("ready", req_ready_o, exp_oh);
        if (exp_oh == 4'b0000) begin
            chk("idle_busy", busy_o, 64'h0);
            req_v_i = 4'b0000;
            return;
        end
        g = 0;
        for (int k = 0; k < 4; k++) if (exp_oh[k]) g = k;
        @(negedge clk);
        req_data_i = {$urandom, $urandom, $urandom, $urandom};
        req_v_i    = 4'($urandom);
        #1;
        chk("issue_v", eng_v_o, 64'h1);
        chk("issue_data", eng_data_o, d[g]);
        chk("issue_dec", eng_dec_o, dec[g]);
        chk("grant", grant_id_o, g);
        chk("ready_busy", req_ready_o, 64'h0);
        for (int s = 0; s < stall; s++) begin
            eng_resp_v_i = 1'b1; eng_resp_data_i = $urandom;
            @(negedge clk);
            req_data_i = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("stall_stable", {eng_v_o, eng_dec_o, eng_data_o}, {1'b1, dec[g], d[g]});
            chk("stall_no_rack", eng_resp_ready_o, 64'h0);
        end
        eng_ready_i = 1'b1; eng_resp_v_i = 1'b0;
        @(negedge clk);
        eng_ready_i = 1'b0;
        #1;
        chk("wait_eng", {eng_v_o, eng_resp_ready_o}, 64'h1);
        chk("wait_eng_data", eng_data_o, 64'h0);
        for (int l = 1; l < lat; l++) begin
            @(negedge clk);
            #1;
            chk("wait_no_resp", resp_v_o, 64'h0);
        end
        res = eng_fn(d[g], dec[g]);
        eng_resp_v_i = 1'b1; eng_resp_data_i = res;
        @(negedge clk);
        eng_resp_v_i = 1'b0; eng_resp_data_i = $urandom;
        #1;
        chk("resp_v", resp_v_o, exp_oh);
        chk("resp_data", resp_data_o, res);
        chk("resp_no_rack", eng_resp_ready_o, 64'h0);
        for (int h = 0; h < hold; h++) begin
            resp_ready_i = ~exp_oh;
            @(negedge clk);
            #1;
            chk("resp_hold", {resp_v_o, resp_data_o}, {exp_oh, res});
        end
        resp_ready_i = exp_oh | 4'($urandom);
        @(negedge clk);
        resp_ready_i = 4'b0000; req_v_i = 4'b0000;
        #1;
        ptr_m = (g + 1) % 4;
        chk_quiet("done");
        chk("done_grant", grant_id_o, g);
`ifdef SM4_ARB_PERF_EN
        perf_m[g] = perf_m[g] + 1;
        for (int k = 0; k < 4; k++)
            chk("perf", perf_cnt_o[k*CW +: CW],
                (perf_m[k] > (1 << CW) - 1) ? (1 << CW) - 1 : perf_m[k]);
`endif
    endtask

    vec_t vecs [10];

    initial begin
        // Expected grants hand-derived from reset (pointer 0), each row completing before the next.
        vecs[0] = '{4'b0100, 4'b0100};
        vecs[1] = '{4'b0011, 4'b0001};
        vecs[2] = '{4'b0011, 4'b0010};
        vecs[3] = '{4'b0000, 4'b0000};
        vecs[4] = '{4'b1111, 4'b0100};
        vecs[5] = '{4'b1111, 4'b1000};
        vecs[6] = '{4'b1111, 4'b0001};
        vecs[7] = '{4'b1001, 4'b1000};
        vecs[8] = '{4'b0110, 4'b0010};
        vecs[9] = '{4'b1010, 4'b1000};

        rst_ni = 1'b1; req_v_i = 4'b0000; req_data_i = '0; req_dec_i = 4'b0000;
        eng_ready_i = 1'b0; eng_resp_v_i = 1'b0; eng_resp_data_i = '0; resp_ready_i = 4'b0000;
        do_reset();

        for (int i = 0; i < 10; i++)
            run_txn(vecs[i].rv, vecs[i].exp_ready, (i == 0) ? 3 : 1 + i % 3, (i % 2) * 2, i % 3);

        // Long engine stall with spurious results, and a response held off by other requesters' ready.
        run_txn(4'b0001, 4'b0001, 2, 5, 3);

        // Reset while waiting for the engine abandons the transaction and clears the pointer.
        @(negedge clk);
        req_v_i = 4'b0010; req_data_i = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        req_v_i = 4'b0000; eng_ready_i = 1'b1;
        @(negedge clk);
        eng_ready_i = 1'b0;
        #1;
        chk("pre_rst_wait", eng_resp_ready_o, 64'h1);
        rst_ni = 1'b0;
        #1;
        chk_quiet("async_rst");
        chk("async_rst_grant", {req_ready_o, grant_id_o}, 64'h0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        run_txn(4'b1001, 4'b0001, 1, 0, 0);

        // Five completions on requester 2 saturate its counter when enabled.
        do_reset();
        for (int i = 0; i < 5; i++) run_txn(4'b0100, 4'b0100, 1 + i % 2, 0, 0);
`ifdef SM4_ARB_PERF_EN
        chk("perf_sat", perf_cnt_o, 64'h30);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [3:0] rv;
            rv = 4'($urandom);
            run_txn(rv, model_grant(rv), $urandom_range(1, 4), $urandom_range(0, 3),
                    $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
